// File: rtl/dynamixel_status_receiver.sv
// Dynamixel Protocol 2.0 status packet parser: header/length/CRC-16 validation, byte de-stuffing,
// echo rejection of non-status packets, one-cycle result pulses with held shadow fields.
module dynamixel_status_receiver #(
  parameter int unsigned timeout_clocks = 100000,
  parameter int unsigned max_length     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  input  logic        byte_error,
  output logic        status_valid,
  output logic [7:0]  status_id,
  output logic [7:0]  status_error,
  output logic [31:0] status_param,
  output logic [7:0]  param_count,
  output logic        crc_error,
  output logic        format_error,
  output logic        busy
);

  typedef enum logic [3:0] {
    StIdle, StH1, StH2, StRsv, StId, StLenL, StLenH, StInst, StErr, StParam, StCrcL, StCrcH
  } state_e;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = {c[14:0], 1'b0} ^ (c[15] ? 16'h8005 : 16'h0000);
    end
    return c;
  endfunction

  // The header is fixed, so its CRC is loaded as a constant once FF FF FD is seen (covers resync).
  localparam logic [15:0] CrcHeader = crc_step(crc_step(crc_step(16'h0000, 8'hFF), 8'hFF), 8'hFD);
  localparam int unsigned TimerW = (timeout_clocks < 2) ? 1 : $clog2(timeout_clocks);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(timeout_clocks - 1);

  state_e            state_q, state_d;
  logic [15:0]       crc_q, crc_d;
  logic [15:0]       rem_q, rem_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [7:0]        crc_lo_q, crc_lo_d;
  logic [7:0]        id_q, id_d;
  logic [7:0]        err_q, err_d;
  logic [31:0]       par_q, par_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ignore_q, ignore_d;
  logic [23:0]       win_q, win_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [7:0]        sh_id_q, sh_id_d;
  logic [7:0]        sh_err_q, sh_err_d;
  logic [31:0]       sh_par_q, sh_par_d;
  logic [7:0]        sh_cnt_q, sh_cnt_d;
  logic              valid_q, valid_d;
  logic              crc_err_q, crc_err_d;
  logic              fmt_err_q, fmt_err_d;

  logic [15:0] crc_next;
  logic [15:0] rem_next;
  logic [15:0] len_full;

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    rem_d     = rem_q;
    len_lo_d  = len_lo_q;
    crc_lo_d  = crc_lo_q;
    id_d      = id_q;
    err_d     = err_q;
    par_d     = par_q;
    cnt_d     = cnt_q;
    ignore_d  = ignore_q;
    win_d     = win_q;
    timer_d   = timer_q;
    sh_id_d   = sh_id_q;
    sh_err_d  = sh_err_q;
    sh_par_d  = sh_par_q;
    sh_cnt_d  = sh_cnt_q;
    valid_d   = 1'b0;
    crc_err_d = 1'b0;
    fmt_err_d = 1'b0;
    crc_next  = crc_step(crc_q, byte_in);
    rem_next  = rem_q - 16'd1;
    len_full  = {byte_in, len_lo_q};

    if (state_q != StIdle && byte_error) begin
      state_d   = StIdle;
      fmt_err_d = 1'b1;
      timer_d   = '0;
    end else if (byte_valid) begin
      // A byte in the expiry cycle wins over the timeout.
      timer_d = '0;
      unique case (state_q)
        StIdle: if (byte_in == 8'hFF) state_d = StH1;
        StH1:   state_d = (byte_in == 8'hFF) ? StH2 : StIdle;
        StH2: begin
          if (byte_in == 8'hFD) begin
            state_d = StRsv;
            crc_d   = CrcHeader;
          end else if (byte_in != 8'hFF) begin
            state_d = StIdle;
          end
        end
        StRsv: begin
          crc_d = crc_next;
          if (byte_in == 8'h00) begin
            state_d = StId;
          end else begin
            state_d   = StIdle;
            fmt_err_d = 1'b1;
          end
        end
        StId: begin
          crc_d   = crc_next;
          id_d    = byte_in;
          state_d = StLenL;
        end
        StLenL: begin
          crc_d    = crc_next;
          len_lo_d = byte_in;
          state_d  = StLenH;
        end
        StLenH: begin
          crc_d = crc_next;
          if (len_full < 16'd4 || 32'(len_full) > max_length) begin
            state_d   = StIdle;
            fmt_err_d = 1'b1;
          end else begin
            rem_d   = len_full;
            state_d = StInst;
          end
        end
        StInst: begin
          crc_d    = crc_next;
          rem_d    = rem_next;
          ignore_d = (byte_in != 8'h55);
          par_d    = '0;
          cnt_d    = '0;
          win_d    = '0;
          state_d  = StErr;
        end
        StErr: begin
          crc_d   = crc_next;
          rem_d   = rem_next;
          err_d   = byte_in;
          state_d = (rem_next == 16'd2) ? StCrcL : StParam;
        end
        StParam: begin
          crc_d = crc_next;
          rem_d = rem_next;
          if (win_q == 24'hFFFFFD && byte_in == 8'hFD) begin
            win_d = '0;
          end else begin
            win_d = {win_q[15:0], byte_in};
            if (cnt_q < 8'd4) par_d[{cnt_q[1:0], 3'b000} +: 8] = byte_in;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          end
          if (rem_next == 16'd2) state_d = StCrcL;
        end
        StCrcL: begin
          rem_d    = rem_next;
          crc_lo_d = byte_in;
          state_d  = StCrcH;
        end
        StCrcH: begin
          rem_d   = rem_next;
          state_d = StIdle;
          if (!ignore_q) begin
            if ({byte_in, crc_lo_q} == crc_q) begin
              valid_d  = 1'b1;
              sh_id_d  = id_q;
              sh_err_d = err_q;
              sh_par_d = par_q;
              sh_cnt_d = cnt_q;
            end else begin
              crc_err_d = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      if (timer_q == TimerLast) begin
        state_d   = StIdle;
        fmt_err_d = 1'b1;
        timer_d   = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      crc_q     <= '0;
      rem_q     <= '0;
      len_lo_q  <= '0;
      crc_lo_q  <= '0;
      id_q      <= '0;
      err_q     <= '0;
      par_q     <= '0;
      cnt_q     <= '0;
      ignore_q  <= 1'b0;
      win_q     <= '0;
      timer_q   <= '0;
      sh_id_q   <= '0;
      sh_err_q  <= '0;
      sh_par_q  <= '0;
      sh_cnt_q  <= '0;
      valid_q   <= 1'b0;
      crc_err_q <= 1'b0;
      fmt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      rem_q     <= rem_d;
      len_lo_q  <= len_lo_d;
      crc_lo_q  <= crc_lo_d;
      id_q      <= id_d;
      err_q     <= err_d;
      par_q     <= par_d;
      cnt_q     <= cnt_d;
      ignore_q  <= ignore_d;
      win_q     <= win_d;
      timer_q   <= timer_d;
      sh_id_q   <= sh_id_d;
      sh_err_q  <= sh_err_d;
      sh_par_q  <= sh_par_d;
      sh_cnt_q  <= sh_cnt_d;
      valid_q   <= valid_d;
      crc_err_q <= crc_err_d;
      fmt_err_q <= fmt_err_d;
    end
  end

  assign status_valid = valid_q;
  assign status_id    = sh_id_q;
  assign status_error = sh_err_q;
  assign status_param = sh_par_q;
  assign param_count  = sh_cnt_q;
  assign crc_error    = crc_err_q;
  assign format_error = fmt_err_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_dynamixel_status_receiver.sv
// Bench for dynamixel_status_receiver: packet-level reference model plus per-cycle output compare.
module tb_dynamixel_status_receiver;

  localparam int Tmo    = 50;
  localparam int MaxLen = 255;
  localparam int KOk = 0, KCrc = 1, KIgn = 2, KFmt = 3;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          kind;
    int          last;
    logic [7:0]  id;
    logic [7:0]  err;
    logic [31:0] param;
    logic [7:0]  cnt;
  } res_t;

  logic        clock, reset_n, byte_valid, byte_error;
  logic [7:0]  byte_in;
  logic        status_valid, crc_error, format_error, busy;
  logic [7:0]  status_id, status_error, param_count;
  logic [31:0] status_param;

  logic        exp_valid, exp_crc, exp_fmt, exp_busy;
  logic [7:0]  exp_id, exp_err, exp_cnt;
  logic [31:0] exp_param;
  int          idle_n;
  int          n_checks, n_fail;

  bq_t ping, ping_bad, ping2, sync_ok, sync_bad, resync, stuff, min_pkt, long_pkt;
  bq_t bad_rsv, len3, len256;

  dynamixel_status_receiver #(.timeout_clocks(Tmo), .max_length(MaxLen)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .byte_valid  (byte_valid),
    .byte_in     (byte_in),
    .byte_error  (byte_error),
    .status_valid(status_valid),
    .status_id   (status_id),
    .status_error(status_error),
    .status_param(status_param),
    .param_count (param_count),
    .crc_error   (crc_error),
    .format_error(format_error),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Serial LFSR form of CRC-16/0x8005, MSB first, init 0.
  function automatic logic [15:0] crc16(input bq_t q, input int first, input int last);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int i = first; i <= last; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ q[i][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    return c;
  endfunction

  function automatic bq_t build(input logic [7:0] id, input logic [7:0] inst, input logic [7:0] err,
                                input logic [127:0] p, input int n, input bit corrupt);
    bq_t         q;
    int          len;
    logic [15:0] c;
    len = n + 4;
    q.push_back(8'hFF); q.push_back(8'hFF); q.push_back(8'hFD); q.push_back(8'h00);
    q.push_back(id); q.push_back(8'(len)); q.push_back(8'(len >> 8));
    q.push_back(inst); q.push_back(err);
    for (int i = 0; i < n; i++) q.push_back((i < 16) ? p[8*i +: 8] : 8'(i * 7 + 1));
    c = crc16(q, 0, q.size() - 1);
    q.push_back(c[7:0]);
    q.push_back(c[15:8] ^ {7'b0, corrupt});
    return q;
  endfunction

  function automatic bq_t hdr(input logic [7:0] rsv, input logic [7:0] ll, input logic [7:0] lh);
    bq_t q;
    q.push_back(8'hFF); q.push_back(8'hFF); q.push_back(8'hFD); q.push_back(rsv);
    q.push_back(8'h06); q.push_back(ll); q.push_back(lh);
    return q;
  endfunction

  // Whole-packet reference: what the packet must produce and at which byte it ends.
  function automatic res_t model(input bq_t p);
    res_t        r;
    bq_t         dst;
    int          len, ws;
    logic [15:0] calc, rx;
    r.kind = KIgn; r.id = p[4]; r.err = 8'h00; r.param = '0; r.cnt = 8'h00;
    if (p[3] != 8'h00) begin
      r.kind = KFmt; r.last = 3;
      return r;
    end
    len = int'({p[6], p[5]});
    if (len < 4 || len > MaxLen) begin
      r.kind = KFmt; r.last = 6;
      return r;
    end
    r.last = 6 + len;
    calc   = crc16(p, 0, 4 + len);
    rx     = {p[6 + len], p[5 + len]};
    if (p[7] != 8'h55) return r;
    r.err = p[8];
    ws = 9;
    for (int i = 9; i <= 4 + len; i++) begin
      if (i - 3 >= ws && p[i-3] == 8'hFF && p[i-2] == 8'hFF && p[i-1] == 8'hFD && p[i] == 8'hFD)
        ws = i + 1;
      else
        dst.push_back(p[i]);
    end
    for (int k = 0; k < 4 && k < dst.size(); k++) r.param[8*k +: 8] = dst[k];
    r.cnt  = (dst.size() > 255) ? 8'hFF : 8'(dst.size());
    r.kind = (calc == rx) ? KOk : KCrc;
    return r;
  endfunction

  always @(negedge clock) begin
    check("status_valid", {31'b0, status_valid}, {31'b0, exp_valid});
    check("crc_error", {31'b0, crc_error}, {31'b0, exp_crc});
    check("format_error", {31'b0, format_error}, {31'b0, exp_fmt});
    check("busy", {31'b0, busy}, {31'b0, exp_busy});
    check("status_id", {24'b0, status_id}, {24'b0, exp_id});
    check("status_error", {24'b0, status_error}, {24'b0, exp_err});
    check("status_param", status_param, exp_param);
    check("param_count", {24'b0, param_count}, {24'b0, exp_cnt});
  end

  task automatic clear_pulses();
    exp_valid = 1'b0; exp_crc = 1'b0; exp_fmt = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] b);
    byte_valid = 1'b1; byte_in = b;
    @(posedge clock); #1;
    byte_valid = 1'b0; byte_in = 8'h00;
    clear_pulses();
    idle_n = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      clear_pulses();
      idle_n++;
      if (exp_busy && idle_n == Tmo) begin
        exp_fmt = 1'b1; exp_busy = 1'b0;
      end
    end
  endtask

  task automatic berr();
    byte_error = 1'b1;
    @(posedge clock); #1;
    byte_error = 1'b0;
    clear_pulses();
    if (exp_busy) begin
      exp_fmt = 1'b1; exp_busy = 1'b0;
    end
  endtask

  task automatic send_pkt(input bq_t pkt, input int gap_idx, input int gap_len);
    res_t r;
    r = model(pkt);
    for (int i = 0; i <= r.last; i++) begin
      strobe(pkt[i]);
      exp_busy = (i < r.last);
      if (i == r.last) begin
        case (r.kind)
          KOk: begin
            exp_valid = 1'b1; exp_id = r.id; exp_err = r.err;
            exp_param = r.param; exp_cnt = r.cnt;
          end
          KCrc:    exp_crc = 1'b1;
          KFmt:    exp_fmt = 1'b1;
          default: ;
        endcase
      end
      if (i == gap_idx) idle(gap_len);
    end
  endtask

  task automatic zero_exp();
    clear_pulses();
    exp_busy = 1'b0; exp_id = '0; exp_err = '0; exp_param = '0; exp_cnt = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_fail = 0; idle_n = 0;
    reset_n = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; byte_error = 1'b0;
    zero_exp();

    ping     = build(8'h01, 8'h55, 8'h00, 128'h26_04_06, 3, 1'b0);
    ping_bad = build(8'h01, 8'h55, 8'h00, 128'h26_04_06, 3, 1'b1);
    ping2    = build(8'h02, 8'h55, 8'h00, 128'h44_33_22_11, 4, 1'b0);
    sync_ok  = build(8'hFE, 8'h83, 8'h74, 128'h66_55_02_44_33_22_11_01_00_04_00, 11, 1'b0);
    sync_bad = build(8'hFE, 8'h83, 8'h74, 128'h66_55_02_44_33_22_11_01_00_04_00, 11, 1'b1);
    resync   = build(8'h03, 8'h55, 8'h80, 128'hEE_DD_CC_BB_AA, 5, 1'b0);
    stuff    = build(8'h04, 8'h55, 8'h00, 128'h02_FD_FD_FF_FF_01, 6, 1'b0);
    min_pkt  = build(8'h05, 8'h55, 8'h07, 128'h0, 0, 1'b0);
    long_pkt = build(8'h09, 8'h55, 8'h00, 128'h0F0E0D0C0B0A09080706050403020110, 251, 1'b0);
    bad_rsv  = hdr(8'h01, 8'h07, 8'h00);
    len3     = hdr(8'h00, 8'h03, 8'h00);
    len256   = hdr(8'h00, 8'h00, 8'h01);

    // Pin the packet builder and CRC against the known ping status bytes.
    check("ping_len", {24'b0, ping[5]}, 32'h07);
    check("ping_crc_l", {24'b0, ping[12]}, 32'h65);
    check("ping_crc_h", {24'b0, ping[13]}, 32'h5D);
    check("ping_bad_crc_h", {24'b0, ping_bad[13]}, 32'h5C);
    check("sync_len", {24'b0, sync_ok[5]}, 32'h0F);

    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    idle(2);

    send_pkt(ping, -1, 0);
    check("ping_valid", {31'b0, status_valid}, 32'h1);
    check("ping_id", {24'b0, status_id}, 32'h01);
    check("ping_param", status_param, 32'h00260406);
    check("ping_cnt", {24'b0, param_count}, 32'h3);
    idle(2);

    send_pkt(ping_bad, -1, 0);
    check("bad_crc_pulse", {31'b0, crc_error}, 32'h1);
    check("bad_no_valid", {31'b0, status_valid}, 32'h0);
    check("bad_param_held", status_param, 32'h00260406);
    idle(2);

    send_pkt(sync_ok, -1, 0);
    send_pkt(ping2, -1, 0);
    check("echo_then_id", {24'b0, status_id}, 32'h02);
    check("echo_then_param", status_param, 32'h44332211);
    idle(1);
    send_pkt(sync_bad, -1, 0);
    check("echo_bad_no_crc", {31'b0, crc_error}, 32'h0);
    send_pkt(ping, -1, 0);
    idle(2);

    strobe(8'h12); exp_busy = 1'b0;
    strobe(8'h34); exp_busy = 1'b0;
    strobe(8'hFF); exp_busy = 1'b1;
    send_pkt(resync, -1, 0);
    check("resync_err", {24'b0, status_error}, 32'h80);
    check("resync_param", status_param, 32'hDDCCBBAA);
    check("resync_cnt", {24'b0, param_count}, 32'h5);
    idle(2);

    send_pkt(stuff, -1, 0);
    check("stuff_cnt", {24'b0, param_count}, 32'h5);
    check("stuff_param", status_param, 32'hFDFFFF01);
    idle(2);

    send_pkt(min_pkt, -1, 0);
    check("min_cnt", {24'b0, param_count}, 32'h0);
    idle(1);
    send_pkt(long_pkt, -1, 0);
    check("long_cnt", {24'b0, param_count}, 32'd251);
    idle(2);

    send_pkt(bad_rsv, -1, 0);
    idle(1);
    send_pkt(len3, -1, 0);
    check("len3_fmt", {31'b0, format_error}, 32'h1);
    idle(1);
    send_pkt(len256, -1, 0);
    idle(2);

    for (int i = 0; i < 6; i++) begin
      strobe(ping[i]); exp_busy = 1'b1;
    end
    idle(Tmo - 1);
    check("tmo_not_yet", {31'b0, format_error}, 32'h0);
    idle(1);
    check("tmo_fmt", {31'b0, format_error}, 32'h1);
    check("tmo_busy", {31'b0, busy}, 32'h0);
    idle(5);

    send_pkt(ping2, 5, Tmo - 1);
    check("gap_valid", {31'b0, status_valid}, 32'h1);
    idle(2);

    for (int i = 0; i < 4; i++) begin
      strobe(ping[i]); exp_busy = 1'b1;
    end
    berr();
    idle(2);

    for (int i = 0; i < 5; i++) begin
      strobe(ping[i]); exp_busy = 1'b1;
    end
    reset_n = 1'b0;
    zero_exp();
    repeat (2) begin @(posedge clock); #1; end
    check("rst_param", status_param, 32'h0);
    reset_n = 1'b1;
    idle(2);
    send_pkt(ping, -1, 0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dynamixel_status_receiver.md
Name: dynamixel_status_receiver

Overview:
Parses Dynamixel Protocol 2.0 status packets from the half-duplex servo bus. It sits downstream of the UART receiver on the same pin that the sync-write transmitter drives, and consumes the received byte stream. It validates the header, length and CRC-16, and removes byte stuffing. It discards echoed instruction packets, including our own sync writes, and reports each valid status packet as a single-cycle result: ID, error byte and up to 4 parameter bytes.

Parameters:
timeout_clocks, 100000, maximum idle clocks between bytes inside a packet before abort; must be >= 1
max_length, 255, largest accepted LENGTH field; larger values are treated as a length error

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
byte_valid  input  1  one-cycle strobe from UART receiver; byte_in is valid
byte_in  input  8  received byte
byte_error  input  1  one-cycle strobe; UART framing error on current byte
status_valid  output  1  one-cycle pulse; good status packet received
status_id  output  8  packet ID, held until next status_valid
status_error  output  8  ERROR byte, held
status_param  output  32  first 4 de-stuffed params, little-endian (param0 in [7:0]); unused bytes 0
param_count  output  8  de-stuffed param byte count, saturating at 255
crc_error  output  1  one-cycle pulse; status packet CRC mismatch
format_error  output  1  one-cycle pulse; bad reserved byte, bad length, byte_error or timeout mid-packet
busy  output  1  high while in any state other than IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; crc 0; timeout counter 0. Reset mid-packet discards the packet and emits no pulse.
- All processing happens on byte_valid cycles. One byte is processed per strobe. Result pulses occur in the cycle after the final CRC byte strobe, giving a latency of 1 clock.
- CRC-16: polynomial 0x8005, init 0x0000, non-reflected, MSB-first. It runs over every byte from the first FF through the last param, including stuffing bytes. It excludes the two CRC bytes. The received CRC arrives LSB first.
- States and transitions on byte_valid:
  - IDLE: FF -> H1; anything else stays in IDLE.
  - H1: FF -> H2; else -> IDLE.
  - H2: FD -> RSV; FF -> H2 (resync); else -> IDLE.
  - RSV: 00 -> ID; else -> IDLE with format_error.
  - ID -> LEN_L -> LEN_H.
  - After LEN_H: if len < 4 or len > max_length -> IDLE with format_error; else -> INST with remaining = len.
  - INST: 0x55 marks a status packet; any other value marks the packet as ignored. Either way -> ERR (ignored packets consume the error byte as a param).
  - ERR -> PARAM, or -> CRC_L if remaining hits 2.
  - PARAM -> CRC_L when remaining hits 2.
  - CRC_L -> CRC_H -> IDLE.
- remaining decrements once per byte from INST onward. It is 16 bits wide and never wraps, because the length check guarantees >= 4.
- Byte stuffing:
  - Track the last 3 payload bytes received in PARAM.
  - If they are FF FF FD and the next byte is FD, that FD is counted in remaining and the CRC but is not stored and does not increment param_count.
  - The tracking window resets after a stuff byte is removed.
- Param capture: de-stuffed param k < 4 goes to byte lane k. Params beyond 4 are consumed, not stored.
- Shadow registers: status_id, status_error, status_param and param_count are updated only together with a status_valid pulse. On crc_error, ignored packets or aborts they keep their old values.
- Ignored (non-0x55) packets: consumed to the end by length, with no status_valid and no crc_error, even if the CRC is bad.
- Status packet CRC compare at CRC_H: match -> status_valid; mismatch -> crc_error. The two pulses are never asserted together.
- byte_error in any non-IDLE state -> IDLE with format_error. In IDLE it is ignored.
- Timeout: a counter clears on every byte_valid. When not IDLE it increments each clock; on reaching timeout_clocks -> IDLE with format_error. In IDLE it is held at 0.
- A byte_valid coinciding with the timeout expiry cycle: the byte wins, the counter clears and no abort occurs.
- Back-to-back packets: a byte strobed in the cycle right after CRC_H is handled from IDLE.

Test Plan:
- Ping status FF FF FD 00 01 07 00 55 00 06 04 26 65 5D -> status_valid pulse once; status_id=01, status_error=00, status_param=0x00260406, param_count=3.
- Same packet with last byte 5C -> crc_error pulse only; shadow outputs unchanged from the previous test.
- Echoed sync write (FF FF FD 00 FE 0F 00 83 74 00 04 00 ..., with a correct or corrupted CRC), followed immediately by a valid ping status -> no pulse for the first packet, status_valid for the second.
- Leading garbage FF FF FF FD 00 ... (triple FF) before a valid packet -> resync; status_valid with correct fields.
- Status with params 01 FF FF FD FD 02 (stuff byte present, len accounting for it, correct CRC) -> param_count=5, status_param=0xFDFFFF01.
- Byte stream stops after LEN_L with timeout_clocks=50 -> format_error pulse 50 clocks after the last strobe, busy=0. Separately, reset_n low mid-packet -> no pulses and all outputs 0.
